control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives the datapath's control inputs. It sequences fetch
//  (T0-T2) and execute (T3-T6) for register, immediate and mul/div ALU instructions,
//  decoding the IR returned over the bus. It is the producer of every strobe the datapath consumes.
// PARAMETERS
//  DATA_W    32  IR width
//  OPCODE_W  5   opcode field width, IR[31:27]
//  REG_W     4   register-field width: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
//  NUM_REGS  16  general registers R0..R15
// PORTS
//  clock      in   1         rising-edge clock
//  clear      in   1         asynchronous, active-low reset
//  ir         in   DATA_W    instruction register contents
//  mem_ready  in   1         memory has valid Mdatain for the current Read
//  start      in   1         leave IDLE and begin fetching
//  reg_in     out  NUM_REGS  one-hot Rxin strobes
//  reg_out    out  NUM_REGS  one-hot Rxout bus-select strobes
//  PCout, Zhighout, Zlowout, MDRout, Cout   out 1 each  bus-source selects, at most one per cycle
//  MARin, PCin, MDRin, IRin, Yin, IncPC, Read, HIin, LOin, ZHighIn, ZLowIn  out 1 each  load strobes
//  alu_op     out  OPCODE_W  ALU operation, valid in T4 only, else 0
//  running    out  1         high in every state except IDLE and HALTED
// BEHAVIOUR
//  - Moore FSM. Outputs are registered from the next state, so each strobe is valid in its named state.
//  - Reset (clear=0): state=IDLE; every output is 0, including reg_in, reg_out and alu_op.
//    Reset mid-instruction aborts immediately. No strobe glitches high on release.
//  - IDLE: waits for start=1, then goes to T0. HALTED: left only by reset.
//  - T0: PCout, MARin, IncPC.  T1: Read, MDRin.  T2: MDRout, IRin.
//  - T3: Rb onto bus (reg_out[Rb]), Yin.
//  - T4: source is reg_out[Rc] for R-type or Cout for imm-type; alu_op=opcode; ZLowIn, ZHighIn.
//  - T5: Zlowout. Destination is reg_in[Ra]; for mul/div it is LOin instead.
//  - T6 (mul/div only): Zhighout, HIin. Then back to T0.
//  - Otherwise T5 -> T0.
//  - Opcode classes:
//    - R-type 0x00-0x08 (add, sub, and, or, shr, shra, shl, ror, rol)
//    - imm-type 0x09-0x0B (addi, andi, ori)
//    - mul 0x0F, div 0x10
//    - nop 0x1A: T2 -> T0 directly
//    - halt 0x1B: T2 -> HALTED
//    - any other value is illegal: treated as nop
//  - Writes with Ra=0 are suppressed (reg_in stays 0); R0 reads are permitted.
//  - reg_in and reg_out are always one-hot or zero. Only one bus-source select is high per cycle.
//  - start while running is ignored.
// CONFIGURATION
//  MEM_WAIT_EN defined: T1 holds, with Read and MDRin high, until mem_ready=1 and then advances.
//    A wait of any length is legal.
//  MEM_WAIT_EN undefined: T1 lasts exactly one cycle and mem_ready is unused.
// STRUCTURE
//  Package cpu_pkg holds the state enum (IDLE, T0..T6, HALTED), opcode localparams,
//  opcode-class functions and IR field position constants.
//  One sub-module, opcode_decoder (combinational):
//    - ir in; is_rtype, is_imm, is_muldiv, is_nop, is_halt, ra, rb, rc out.
//  The FSM and the output register live in control_sequencer.
// TESTING
//  - Reset: hold clear=0 for 3 cycles, with start=1 -> all outputs 0 and state IDLE;
//    release clear -> T0 on the first edge after start.
//  - add R1,R2,R3 (ir=0x0091_8000): T3 reg_out=0x0004 with Yin; T4 reg_out=0x0008, alu_op=0;
//    T5 Zlowout, reg_in=0x0002. Instruction is 6 cycles total.
//  - addi R4,R5,#-3: T4 Cout=1, reg_out=0, alu_op=0x09; T5 reg_in=0x0010.
//  - mul R6,R7 (opcode 0x0F): T5 Zlowout+LOin, T6 Zhighout+HIin, reg_in=0 throughout.
//  - MEM_WAIT_EN with mem_ready low for 4 cycles -> T1 held 5 cycles, Read stays high.
//    Without MEM_WAIT_EN -> T1 lasts 1 cycle.
//  - halt (0xD800_0000) -> HALTED, running=0, start ignored. clear pulse mid-T4 -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit.
// Contents:
//   - datapath sizing (IR width, opcode/register field widths, register count)
//   - IR field bit positions
//   - opcode constants and opcode-class helper functions
//   - state_t: sequencer states IDLE, T0..T6, HALTED
//   - ctrl_t: the full set of control strobes as one registered bundle
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int OPCODE_W = 5;
    localparam int REG_W    = 4;
    localparam int NUM_REGS = 16;

    // IR field positions: opcode | Ra | Rb | Rc | (immediate / unused)
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Opcode values that bound or name the instruction classes
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'h08;  // last R-type (add..rol = 0x00..0x08)
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'h09;  // first imm-type
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'h0B;  // last imm-type
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'h0F;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'h10;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'h1A;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'h1B;

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        HALTED
    } state_t;

    typedef struct packed {
        logic [NUM_REGS-1:0] reg_in;
        logic [NUM_REGS-1:0] reg_out;
        logic                PCout;
        logic                Zhighout;
        logic                Zlowout;
        logic                MDRout;
        logic                Cout;
        logic                MARin;
        logic                PCin;
        logic                MDRin;
        logic                IRin;
        logic                Yin;
        logic                IncPC;
        logic                Read;
        logic                HIin;
        logic                LOin;
        logic                ZHighIn;
        logic                ZLowIn;
        logic [OPCODE_W-1:0] alu_op;
        logic                running;
    } ctrl_t;

    function automatic logic is_rtype_op(input logic [OPCODE_W-1:0] op);
        return op <= OP_ROL;
    endfunction

    function automatic logic is_imm_op(input logic [OPCODE_W-1:0] op);
        return (op >= OP_ADDI) && (op <= OP_ORI);
    endfunction

    function automatic logic is_muldiv_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_halt_op(input logic [OPCODE_W-1:0] op);
        return op == OP_HALT;
    endfunction

    // Register number to one-hot strobe vector
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and the datapath.
// Signals:
//   ir, mem_ready, start           datapath -> sequencer
//   reg_in, reg_out                one-hot register load / bus-drive strobes
//   PCout..Cout                    bus-source selects (at most one per cycle)
//   MARin..ZLowIn                  load strobes
//   alu_op                         ALU operation (non-zero only in T4)
//   running                        sequencer is fetching/executing
// Modports: master = sequencer side, slave = datapath side.
//
// Handshake: the only flow-control signal is mem_ready. The sequencer
// raises Read in T1 (the request, acting as valid); with MEM_WAIT_EN the
// memory answers with mem_ready (acting as ready) and the read completes on
// the first rising edge where Read and mem_ready are both high. Read stays
// high and T1 holds for as long as mem_ready is low.
interface control_sequencer_if;
    import cpu_pkg::*;

    logic [DATA_W-1:0]   ir;
    logic                mem_ready;
    logic                start;

    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic                PCout;
    logic                Zhighout;
    logic                Zlowout;
    logic                MDRout;
    logic                Cout;
    logic                MARin;
    logic                PCin;
    logic                MDRin;
    logic                IRin;
    logic                Yin;
    logic                IncPC;
    logic                Read;
    logic                HIin;
    logic                LOin;
    logic                ZHighIn;
    logic                ZLowIn;
    logic [OPCODE_W-1:0] alu_op;
    logic                running;

    modport master (
        input  ir, mem_ready, start,
        output reg_in, reg_out,
        output PCout, Zhighout, Zlowout, MDRout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, IncPC, Read, HIin, LOin, ZHighIn, ZLowIn,
        output alu_op, running
    );

    modport slave (
        output ir, mem_ready, start,
        input  reg_in, reg_out,
        input  PCout, Zhighout, Zlowout, MDRout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, IncPC, Read, HIin, LOin, ZHighIn, ZLowIn,
        input  alu_op, running
    );

endinterface

// File: rtl/opcode_decoder.sv
// Combinational IR decoder.
// Ports:
//   ir         in   instruction register contents
//   opcode     out  IR[31:27]
//   is_rtype   out  add..rol (0x00-0x08)
//   is_imm     out  addi/andi/ori (0x09-0x0B)
//   is_muldiv  out  mul (0x0F) / div (0x10)
//   is_nop     out  nop (0x1A) or any unassigned opcode
//   is_halt    out  halt (0x1B)
//   ra, rb, rc out  register fields IR[26:23], IR[22:19], IR[18:15]
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0]   ir,
    output logic [OPCODE_W-1:0] opcode,
    output logic                is_rtype,
    output logic                is_imm,
    output logic                is_muldiv,
    output logic                is_nop,
    output logic                is_halt,
    output logic [REG_W-1:0]    ra,
    output logic [REG_W-1:0]    rb,
    output logic [REG_W-1:0]    rc
);

    // The immediate field is consumed by the datapath, not by control
    logic unused_imm;

    assign opcode    = ir[OP_MSB:OP_LSB];
    assign ra        = ir[RA_MSB:RA_LSB];
    assign rb        = ir[RB_MSB:RB_LSB];
    assign rc        = ir[RC_MSB:RC_LSB];

    assign is_rtype  = is_rtype_op(opcode);
    assign is_imm    = is_imm_op(opcode);
    assign is_muldiv = is_muldiv_op(opcode);
    assign is_halt   = is_halt_op(opcode);
    // Unassigned opcodes fall through to nop so they only cost a fetch
    assign is_nop    = (opcode == OP_NOP) || !(is_rtype || is_imm || is_muldiv || is_halt);

    assign unused_imm = ^ir[RC_LSB-1:0];

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: sequences fetch (T0-T2) and execute (T3-T6) for
// register, immediate and mul/div ALU instructions and drives every datapath
// control strobe.
// Ports:
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-low reset
//   bus        master modport of control_sequencer_if (ir/mem_ready/start in,
//              all strobes, alu_op and running out)
//   dbg_state  out  current sequencer state
// Build option: MEM_WAIT_EN -- when defined, T1 holds until mem_ready=1;
// otherwise T1 is a single cycle and mem_ready is ignored.
//
// Outputs are Moore-style and registered from next_state, so each strobe is
// high exactly while the FSM sits in the state that names it, with no
// combinational glitches. The IR must be valid by T2, where nop/halt are
// resolved.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                       clock,
    input  logic                       clear,
    control_sequencer_if.master        bus,
    output state_t                     dbg_state
);

    logic [OPCODE_W-1:0] opcode;
    logic                is_rtype;
    logic                is_imm;
    logic                is_muldiv;
    logic                is_nop;
    logic                is_halt;
    logic [REG_W-1:0]    ra;
    logic [REG_W-1:0]    rb;
    logic [REG_W-1:0]    rc;

    state_t state;
    state_t next_state;
    ctrl_t  ctrl_d;
    ctrl_t  ctrl_q;

    opcode_decoder u_dec (
        .ir        (bus.ir),
        .opcode    (opcode),
        .is_rtype  (is_rtype),
        .is_imm    (is_imm),
        .is_muldiv (is_muldiv),
        .is_nop    (is_nop),
        .is_halt   (is_halt),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (bus.start) next_state = T0;
            T0:     next_state = T1;
`ifdef MEM_WAIT_EN
            T1:     if (bus.mem_ready) next_state = T2;
`else
            T1:     next_state = T2;
`endif
            T2: begin
                if (is_halt) begin
                    next_state = HALTED;
                end else if (is_nop) begin
                    next_state = T0;
                end else begin
                    next_state = T3;
                end
            end
            T3:     next_state = T4;
            T4:     next_state = T5;
            T5:     next_state = is_muldiv ? T6 : T0;
            T6:     next_state = T0;
            HALTED: next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

`ifndef MEM_WAIT_EN
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
`endif

    // Strobes for the state being entered
    always_comb begin
        ctrl_d         = '0;
        ctrl_d.running = (next_state != IDLE) && (next_state != HALTED);
        case (next_state)
            T0: begin
                ctrl_d.PCout = 1'b1;
                ctrl_d.MARin = 1'b1;
                ctrl_d.IncPC = 1'b1;
            end
            T1: begin
                ctrl_d.Read  = 1'b1;
                ctrl_d.MDRin = 1'b1;
            end
            T2: begin
                ctrl_d.MDRout = 1'b1;
                ctrl_d.IRin   = 1'b1;
            end
            T3: begin
                ctrl_d.reg_out = reg_onehot(rb);
                ctrl_d.Yin     = 1'b1;
            end
            T4: begin
                if (is_imm) begin
                    ctrl_d.Cout = 1'b1;
                end else begin
                    ctrl_d.reg_out = reg_onehot(rc);
                end
                ctrl_d.alu_op  = opcode;
                ctrl_d.ZLowIn  = 1'b1;
                ctrl_d.ZHighIn = 1'b1;
            end
            T5: begin
                ctrl_d.Zlowout = 1'b1;
                if (is_muldiv) begin
                    ctrl_d.LOin = 1'b1;
                end else if (ra != '0) begin
                    // R0 is read-only: writes to it are dropped
                    ctrl_d.reg_in = reg_onehot(ra);
                end
            end
            T6: begin
                ctrl_d.Zhighout = 1'b1;
                ctrl_d.HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.reg_in   = ctrl_q.reg_in;
    assign bus.reg_out  = ctrl_q.reg_out;
    assign bus.PCout    = ctrl_q.PCout;
    assign bus.Zhighout = ctrl_q.Zhighout;
    assign bus.Zlowout  = ctrl_q.Zlowout;
    assign bus.MDRout   = ctrl_q.MDRout;
    assign bus.Cout     = ctrl_q.Cout;
    assign bus.MARin    = ctrl_q.MARin;
    assign bus.PCin     = ctrl_q.PCin;
    assign bus.MDRin    = ctrl_q.MDRin;
    assign bus.IRin     = ctrl_q.IRin;
    assign bus.Yin      = ctrl_q.Yin;
    assign bus.IncPC    = ctrl_q.IncPC;
    assign bus.Read     = ctrl_q.Read;
    assign bus.HIin     = ctrl_q.HIin;
    assign bus.LOin     = ctrl_q.LOin;
    assign bus.ZHighIn  = ctrl_q.ZHighIn;
    assign bus.ZLowIn   = ctrl_q.ZLowIn;
    assign bus.alu_op   = ctrl_q.alu_op;
    assign bus.running  = ctrl_q.running;

    assign dbg_state = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: reset, table of hand-decoded instructions,
// memory-wait case, random instruction stream against a per-cycle trace
// model, halt, and clear asserted mid-execute.
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam int OW = 54;

    typedef struct packed {
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic        PCout;
        logic        Zhighout;
        logic        Zlowout;
        logic        MDRout;
        logic        Cout;
        logic        MARin;
        logic        PCin;
        logic        MDRin;
        logic        IRin;
        logic        Yin;
        logic        IncPC;
        logic        Read;
        logic        HIin;
        logic        LOin;
        logic        ZHighIn;
        logic        ZLowIn;
        logic [4:0]  alu_op;
        logic        running;
    } outs_t;

    typedef struct {
        logic [31:0] ir;
        int          len;
        logic [15:0] t3_out;
        logic [15:0] t4_out;
        logic        t4_cout;
        logic [4:0]  op;
        logic [15:0] t5_in;
        logic        t5_lo;
    } vec_t;

    logic   clock;
    logic   clear;
    state_t dbg_state;

    control_sequencer_if bus();

    control_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    logic [OW-1:0] exp_q[$];
    logic          mr_q[$];
    outs_t         obs[32];
    int            n_obs;
    vec_t          vecs[9];

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: got timeout, required finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- helpers ----------------
    function automatic outs_t sample_outs();
        outs_t o;
        o.reg_in   = bus.reg_in;
        o.reg_out  = bus.reg_out;
        o.PCout    = bus.PCout;
        o.Zhighout = bus.Zhighout;
        o.Zlowout  = bus.Zlowout;
        o.MDRout   = bus.MDRout;
        o.Cout     = bus.Cout;
        o.MARin    = bus.MARin;
        o.PCin     = bus.PCin;
        o.MDRin    = bus.MDRin;
        o.IRin     = bus.IRin;
        o.Yin      = bus.Yin;
        o.IncPC    = bus.IncPC;
        o.Read     = bus.Read;
        o.HIin     = bus.HIin;
        o.LOin     = bus.LOin;
        o.ZHighIn  = bus.ZHighIn;
        o.ZLowIn   = bus.ZLowIn;
        o.alu_op   = bus.alu_op;
        o.running  = bus.running;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t act, input outs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Builds the cycle-by-cycle list of strobes one instruction produces,
    // starting at its T0, plus the mem_ready value to drive in each cycle.
    task automatic build_trace(input logic [31:0] ir, input int wait_n);
        outs_t       o;
        logic [4:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        bit          rtype;
        bit          imm;
        bit          md;
        op = ir[31:27];
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        rtype = (op <= 5'd8);
        imm   = (op >= 5'd9) && (op <= 5'd11);
        md    = (op == 5'd15) || (op == 5'd16);

        o = '0; o.running = 1'b1; o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1;
        exp_q.push_back(o); mr_q.push_back(1'b0);
`ifdef MEM_WAIT_EN
        for (int k = 0; k <= wait_n; k++) begin
            o = '0; o.running = 1'b1; o.Read = 1'b1; o.MDRin = 1'b1;
            exp_q.push_back(o); mr_q.push_back(k == wait_n);
        end
`else
        o = '0; o.running = 1'b1; o.Read = 1'b1; o.MDRin = 1'b1;
        exp_q.push_back(o); mr_q.push_back(wait_n[0]);
`endif
        o = '0; o.running = 1'b1; o.MDRout = 1'b1; o.IRin = 1'b1;
        exp_q.push_back(o); mr_q.push_back(1'b0);

        if (rtype || imm || md) begin
            o = '0; o.running = 1'b1; o.reg_out = 16'(1) << rb; o.Yin = 1'b1;
            exp_q.push_back(o); mr_q.push_back(1'b0);
            o = '0; o.running = 1'b1; o.alu_op = op; o.ZLowIn = 1'b1; o.ZHighIn = 1'b1;
            if (imm) o.Cout = 1'b1;
            else     o.reg_out = 16'(1) << rc;
            exp_q.push_back(o); mr_q.push_back(1'b0);
            o = '0; o.running = 1'b1; o.Zlowout = 1'b1;
            if (md)             o.LOin = 1'b1;
            else if (ra != 0)   o.reg_in = 16'(1) << ra;
            exp_q.push_back(o); mr_q.push_back(1'b0);
            if (md) begin
                o = '0; o.running = 1'b1; o.Zhighout = 1'b1; o.HIin = 1'b1;
                exp_q.push_back(o); mr_q.push_back(1'b0);
            end
        end
    endtask

    // ---------------- driver ----------------
    // Entered #1 after the edge that put the DUT in T0; leaves at the same
    // point of the following instruction (or of HALTED).
    task automatic run_instr(input logic [31:0] ir, input int wait_n, input string name);
        outs_t e;
        outs_t a;
        exp_q.delete();
        mr_q.delete();
        n_obs  = 0;
        bus.ir = ir;
        build_trace(ir, wait_n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.mem_ready = mr_q.pop_front();
            @(negedge clock);
            a = sample_outs();
            if (n_obs < 32) obs[n_obs] = a;
            check_outs($sformatf("%s ir=%h c%0d", name, ir, n_obs), a, e);
            n_obs++;
            @(posedge clock);
            #1;
        end
        bus.mem_ready = 1'b0;
    endtask

    // ---------------- main ----------------
    initial begin
        vecs[0] = '{32'h0091_8000, 6, 16'h0004, 16'h0008, 1'b0, 5'h00, 16'h0002, 1'b0}; // add R1,R2,R3
        vecs[1] = '{32'h4A2F_FFFD, 6, 16'h0020, 16'h0000, 1'b1, 5'h09, 16'h0010, 1'b0}; // addi R4,R5,#-3
        vecs[2] = '{32'h7833_8000, 7, 16'h0040, 16'h0080, 1'b0, 5'h0F, 16'h0000, 1'b1}; // mul R6,R7
        vecs[3] = '{32'h8009_0000, 7, 16'h0002, 16'h0004, 1'b0, 5'h10, 16'h0000, 1'b1}; // div R1,R2
        vecs[4] = '{32'h0878_0000, 6, 16'h8000, 16'h0001, 1'b0, 5'h01, 16'h0000, 1'b0}; // sub R0,R15,R0
        vecs[5] = '{32'hD000_0000, 3, 16'h0000, 16'h0000, 1'b0, 5'h00, 16'h0000, 1'b0}; // nop
        vecs[6] = '{32'h6123_4567, 3, 16'h0000, 16'h0000, 1'b0, 5'h00, 16'h0000, 1'b0}; // illegal 0x0C
        vecs[7] = '{32'h3FF6_8000, 6, 16'h4000, 16'h2000, 1'b0, 5'h07, 16'h8000, 1'b0}; // ror R15,R14,R13
        vecs[8] = '{32'h5980_1234, 6, 16'h0001, 16'h0000, 1'b1, 5'h0B, 16'h0008, 1'b0}; // ori R3,R0,#0x1234

        clear         = 1'b0;
        bus.start     = 1'b1;
        bus.ir        = '0;
        bus.mem_ready = 1'b0;

        // Reset held for 3 cycles with start high
        repeat (3) begin
            @(negedge clock);
            check_outs("reset outs", sample_outs(), '0);
            check_val("reset state", 32'(dbg_state), 32'(IDLE));
        end
        clear = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;

        // Table of hand-decoded instructions
        for (int i = 0; i < 9; i++) begin
            run_instr(vecs[i].ir, 0, "vec");
            check_val($sformatf("len %0d back at T0", i), 32'(dbg_state), 32'(T0));
            check_val($sformatf("len %0d", i), 32'(n_obs), 32'(vecs[i].len));
            if (vecs[i].len > 3) begin
                check_val($sformatf("t3 reg_out %0d", i), 32'(obs[3].reg_out), 32'(vecs[i].t3_out));
                check_val($sformatf("t4 reg_out %0d", i), 32'(obs[4].reg_out), 32'(vecs[i].t4_out));
                check_val($sformatf("t4 Cout %0d", i), 32'(obs[4].Cout), 32'(vecs[i].t4_cout));
                check_val($sformatf("t4 alu_op %0d", i), 32'(obs[4].alu_op), 32'(vecs[i].op));
                check_val($sformatf("t5 reg_in %0d", i), 32'(obs[5].reg_in), 32'(vecs[i].t5_in));
                check_val($sformatf("t5 LOin %0d", i), 32'(obs[5].LOin), 32'(vecs[i].t5_lo));
            end
            if (vecs[i].len == 7) begin
                check_val($sformatf("t6 HIin %0d", i), 32'(obs[6].HIin), 32'(1));
            end
        end

        // mem_ready low for the first 4 T1 cycles
        run_instr(32'h0091_8000, 4, "memwait");
`ifdef MEM_WAIT_EN
        for (int k = 1; k <= 5; k++) begin
            check_val($sformatf("memwait Read c%0d", k), 32'(obs[k].Read), 32'(1));
        end
        check_val("memwait T2 after 5", 32'(obs[6].MDRout), 32'(1));
`else
        check_val("nowait Read c1", 32'(obs[1].Read), 32'(1));
        check_val("nowait T2 at c2", 32'(obs[2].MDRout), 32'(1));
        check_val("nowait Read c2", 32'(obs[2].Read), 32'(0));
`endif

        // Random instruction stream
        for (int i = 0; i < 30; i++) begin
            logic [31:0] r;
            logic [4:0]  op;
            r  = $urandom();
            op = 5'($urandom_range(0, 31));
            if (op == 5'h1B) op = 5'h00;
            run_instr({op, r[26:0]}, int'($urandom_range(0, 5)), "rand");
        end

        // halt, then start must be ignored
        run_instr(32'hD800_0000, 0, "halt");
        for (int k = 0; k < 5; k++) begin
            bus.start = 1'($urandom_range(0, 1)) | (k == 0);
            @(negedge clock);
            check_outs($sformatf("halted outs c%0d", k), sample_outs(), '0);
            check_val($sformatf("halted state c%0d", k), 32'(dbg_state), 32'(HALTED));
        end
        bus.start = 1'b0;

        // Recover with reset, then clear pulse in the middle of T4
        clear = 1'b0;
        @(negedge clock);
        clear     = 1'b1;
        bus.start = 1'b1;
        bus.ir    = 32'h0091_8000;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check_val("pre-clear T4 ZLowIn", 32'(bus.ZLowIn), 32'(1));
        check_val("pre-clear T4 state", 32'(dbg_state), 32'(T4));
        clear = 1'b0;
        #1;
        check_outs("clear mid-T4 outs", sample_outs(), '0);
        check_val("clear mid-T4 state", 32'(dbg_state), 32'(IDLE));
        @(negedge clock);
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_outs($sformatf("post-clear outs c%0d", k), sample_outs(), '0);
            check_val($sformatf("post-clear state c%0d", k), 32'(dbg_state), 32'(IDLE));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
